// File: rtl/req_priority_encoder_if.sv
// Request/index bundle for req_priority_encoder: sticky request lines in,
// registered index handshake and status out.
interface req_priority_encoder_if #(
    parameter int N = 4
);
    localparam int W = $clog2(N);

    logic [N-1:0] req;
    logic [W-1:0] out_idx;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] pending;
    logic         overflow;

    // master is the encoder, slave is the request source / index consumer
    modport master (
        input  req,
        input  out_ready,
        output out_idx,
        output out_valid,
        output pending,
        output overflow
    );

    modport slave (
        output req,
        output out_ready,
        input  out_idx,
        input  out_valid,
        input  pending,
        input  overflow
    );
endinterface

// File: rtl/req_priority_encoder.sv
// Sequential N-to-log2(N) priority encoder: sticky pending mask, highest bit
// wins, registered valid/ready index output with one index per cycle.
module req_priority_encoder #(
    parameter int N = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    req_priority_encoder_if.master bus
);
    localparam int W = $clog2(N);

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic [N-1:0]   pending_q;
    logic [W-1:0]   idx_q;
    logic           valid_q;
    logic           overflow_q;
    logic           load;
    logic [W-1:0]   win;
    logic [N-1:0]   clr_mask;

    // Later iterations overwrite earlier ones, so the highest set bit wins.
    function automatic logic [W-1:0] top_index(input logic [N-1:0] v);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            if (v[i]) r = W'(i);
        end
        return r;
    endfunction

    assign win      = top_index(pending_q);
    assign clr_mask = load ? (N'(1) << win) : '0;

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (pending_q != '0) begin
                    load    = 1'b1;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (bus.out_ready) begin
                    if (pending_q != '0) load = 1'b1;
                    else                 state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            idx_q      <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            // A req on the bit being cleared re-arms it as a fresh event.
            pending_q  <= (pending_q & ~clr_mask) | bus.req;
            overflow_q <= |(bus.req & pending_q & ~clr_mask);
            valid_q    <= (state_d == PRESENT);
            if (load) idx_q <= win;
        end
    end

    assign bus.out_idx   = idx_q;
    assign bus.out_valid = valid_q;
    assign bus.pending   = pending_q;
    assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_req_priority_encoder.sv
// Directed self-checking bench for req_priority_encoder (N=4); each snapshot
// packs {out_valid, out_idx, pending, overflow} after a rising edge.
module tb_req_priority_encoder;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    req_priority_encoder_if #(.N(4)) bus ();

    req_priority_encoder #(.N(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    logic [7:0] snap;
    assign snap = {bus.out_valid, bus.out_idx, bus.pending, bus.overflow};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bus.req = 4'b1111; bus.out_ready = 1'b1;
        tick();
        n_cmp++; if (snap !== 8'b0_00_0000_0) begin n_err++; $display("FAIL reset_c1: got %b want %b", snap, 8'b0_00_0000_0); end
        tick();
        n_cmp++; if (snap !== 8'b0_00_0000_0) begin n_err++; $display("FAIL reset_c2: got %b want %b", snap, 8'b0_00_0000_0); end
        rst_n = 1'b1; bus.req = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (snap !== 8'b0_00_0000_0) begin n_err++; $display("FAIL reset_idle%0d: got %b want %b", i, snap, 8'b0_00_0000_0); end
        end
    endtask

    task automatic test_single();
        bus.out_ready = 1'b1; bus.req = 4'b0100;
        tick(); bus.req = 4'b0000;
        n_cmp++; if (snap !== 8'b0_00_0100_0) begin n_err++; $display("FAIL single_e1: got %b want %b", snap, 8'b0_00_0100_0); end
        tick();
        n_cmp++; if (snap !== 8'b1_10_0000_0) begin n_err++; $display("FAIL single_e2: got %b want %b", snap, 8'b1_10_0000_0); end
        tick();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL single_e3: got valid=%b want 0", bus.out_valid); end
    endtask

    task automatic test_multi();
        bus.out_ready = 1'b1; bus.req = 4'b1011;
        tick(); bus.req = 4'b0000;
        n_cmp++; if (snap !== 8'b0_10_1011_0) begin n_err++; $display("FAIL multi_e1: got %b want %b", snap, 8'b0_10_1011_0); end
        tick();
        n_cmp++; if (snap !== 8'b1_11_0011_0) begin n_err++; $display("FAIL multi_idx3: got %b want %b", snap, 8'b1_11_0011_0); end
        tick();
        n_cmp++; if (snap !== 8'b1_01_0001_0) begin n_err++; $display("FAIL multi_idx1: got %b want %b", snap, 8'b1_01_0001_0); end
        tick();
        n_cmp++; if (snap !== 8'b1_00_0000_0) begin n_err++; $display("FAIL multi_idx0: got %b want %b", snap, 8'b1_00_0000_0); end
        tick();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL multi_end: got valid=%b want 0", bus.out_valid); end
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0; bus.req = 4'b0001;
        tick(); bus.req = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++; if (snap !== 8'b1_00_0000_0) begin n_err++; $display("FAIL bp_hold%0d: got %b want %b", i, snap, 8'b1_00_0000_0); end
        end
        bus.out_ready = 1'b1;
        tick();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL bp_accept: got valid=%b want 0", bus.out_valid); end
    endtask

    task automatic test_overflow();
        bus.out_ready = 1'b0; bus.req = 4'b0010;
        tick(); bus.req = 4'b0000;
        n_cmp++; if (snap !== 8'b0_00_0010_0) begin n_err++; $display("FAIL ovf_e1: got %b want %b", snap, 8'b0_00_0010_0); end
        tick(); bus.req = 4'b0010;
        n_cmp++; if (snap !== 8'b1_01_0000_0) begin n_err++; $display("FAIL ovf_e2: got %b want %b", snap, 8'b1_01_0000_0); end
        tick(); bus.req = 4'b0010;
        n_cmp++; if (snap !== 8'b1_01_0010_0) begin n_err++; $display("FAIL ovf_e3: got %b want %b", snap, 8'b1_01_0010_0); end
        tick(); bus.req = 4'b0000;
        n_cmp++; if (snap !== 8'b1_01_0010_1) begin n_err++; $display("FAIL ovf_e4: got %b want %b", snap, 8'b1_01_0010_1); end
        tick();
        n_cmp++; if (snap !== 8'b1_01_0010_0) begin n_err++; $display("FAIL ovf_e5: got %b want %b", snap, 8'b1_01_0010_0); end
        bus.out_ready = 1'b1;
        tick();
        n_cmp++; if (snap !== 8'b1_01_0000_0) begin n_err++; $display("FAIL ovf_drain: got %b want %b", snap, 8'b1_01_0000_0); end
        tick();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL ovf_idle: got valid=%b want 0", bus.out_valid); end
    endtask

    task automatic test_same_bit_rearm();
        bus.out_ready = 1'b0; bus.req = 4'b0001;
        tick();
        tick(); bus.req = 4'b0000;
        n_cmp++; if (snap !== 8'b1_00_0001_0) begin n_err++; $display("FAIL rearm_load: got %b want %b", snap, 8'b1_00_0001_0); end
        bus.out_ready = 1'b1;
        tick();
        n_cmp++; if (snap !== 8'b1_00_0000_0) begin n_err++; $display("FAIL rearm_b2b: got %b want %b", snap, 8'b1_00_0000_0); end
        tick();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rearm_idle: got valid=%b want 0", bus.out_valid); end
    endtask

    task automatic test_no_preempt();
        bus.out_ready = 1'b0; bus.req = 4'b0001;
        tick(); bus.req = 4'b0000;
        tick(); bus.req = 4'b1000;
        tick(); bus.req = 4'b0000;
        n_cmp++; if (snap !== 8'b1_00_1000_0) begin n_err++; $display("FAIL npe_hold: got %b want %b", snap, 8'b1_00_1000_0); end
        bus.out_ready = 1'b1;
        tick();
        n_cmp++; if (snap !== 8'b1_11_0000_0) begin n_err++; $display("FAIL npe_next: got %b want %b", snap, 8'b1_11_0000_0); end
        tick();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL npe_idle: got valid=%b want 0", bus.out_valid); end
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0; bus.req = 4'b1110;
        tick(); bus.req = 4'b0000;
        tick();
        n_cmp++; if (snap !== 8'b1_11_0110_0) begin n_err++; $display("FAIL rmid_pre: got %b want %b", snap, 8'b1_11_0110_0); end
        rst_n = 1'b0; bus.out_ready = 1'b1; bus.req = 4'b0001;
        tick();
        n_cmp++; if (snap !== 8'b0_00_0000_0) begin n_err++; $display("FAIL rmid_rst: got %b want %b", snap, 8'b0_00_0000_0); end
        rst_n = 1'b1; bus.req = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (snap !== 8'b0_00_0000_0) begin n_err++; $display("FAIL rmid_after%0d: got %b want %b", i, snap, 8'b0_00_0000_0); end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.req = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_single();
        test_multi();
        test_backpressure();
        test_overflow();
        test_same_bit_rearm();
        test_no_preempt();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/req_priority_encoder.md
Name: req_priority_encoder

Overview:
- Sequential N-to-log2(N) priority encoder. It is the encode-side counterpart of the team's 2-to-4 one-hot decoders.
- Captures request lines into a sticky pending register and presents the highest-priority pending index on a registered valid/ready output.
- Clears each request once its index has been loaded for delivery.
- Used wherever one-hot or multi-hot event lines must be serialised into binary indices, for example to drive a downstream decoder.

Parameters:
- N, 4, number of request lines; power of two, N >= 2.
- W, $clog2(N) (2 at default), width of the encoded index. Derived; do not override.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- req  input  N  request lines, sampled every cycle. A 1 on bit i registers an event for index i.
- out_idx  output  W  encoded index of the presented request.
- out_valid  output  1  out_idx holds a valid index.
- out_ready  input  1  consumer accepts out_idx when out_valid && out_ready at a rising edge.
- pending  output  N  registered pending mask, for visibility.
- overflow  output  1  registered one-cycle pulse: an event was lost on a still-pending bit.

Behaviour:
- Reset: rst_n sampled low at a rising edge gives pending=0, out_valid=0, out_idx=0, overflow=0, state=IDLE.
  - Reset overrides all other activity, including a handshake in flight and req asserted in the same cycle.
- Priority: highest set bit of pending wins (bit N-1 highest, bit 0 lowest). Only the registered pending is used; the current req never reaches out_idx combinationally.
- Load event: out_idx <= index of the winning bit, out_valid <= 1, and the winning bit is cleared from pending on the same edge.
- Pending update per edge: pending <= (pending & ~clr_mask) | req.
  - clr_mask is the one-hot of the bit being loaded, or 0 if nothing loads.
  - A req on the same bit being cleared in that cycle re-sets the bit. It counts as a new event, not overflow.
- overflow <= |(req & pending & ~clr_mask). The pulse lasts exactly one cycle per colliding cycle. Colliding events are merged, and one delivery covers them.
- State machine, two states:
  - IDLE: out_valid=0. If pending != 0, perform a load and go to PRESENT; otherwise stay.
  - PRESENT: out_valid=1. out_idx is stable while out_ready=0.
    - On out_ready=1 with pending != 0, load the next winner on the same edge and stay in PRESENT (back-to-back, one index per cycle).
    - On out_ready=1 with pending == 0, out_valid <= 0 and go to IDLE.
- Latency: req high in cycle t sets pending after edge t+1. out_valid rises after edge t+2 when idle. Sustained throughput is 1 index/cycle with out_ready held high.
- A higher-priority req arriving while PRESENT does not pre-empt the presented index. It wins at the next load.
- req=0 with pending=0 keeps the block in IDLE. Outputs hold their last out_idx value (don't-care while out_valid=0).
- All outputs are driven directly from flops.

Test Plan:
- Reset priority: rst_n=0 for 2 cycles with req=1111, out_ready=1 -> pending=0000, out_valid=0, out_idx=00, overflow=0 throughout. After release with req=0, all outputs stay 0.
- Single event: req=0100 for one cycle (cycle 0), out_ready=1 -> pending=0100 after edge 1; out_valid=1, out_idx=10, pending=0000 after edge 2; out_valid=0 after edge 3.
- Multi-hot ordering: req=1011 for one cycle, out_ready=1 -> out_idx sequence 11, 01, 00 on three consecutive valid cycles, then out_valid=0. No gaps, no repeats.
- Backpressure: req=0001 once, out_ready=0 for 5 cycles -> out_valid=1, out_idx=00 stable all 5 cycles. Then out_ready=1 for 1 cycle -> accepted, out_valid=0 on the next cycle.
- Overflow: out_ready=0 throughout. req=0010 in cycle 0 loads at edge 2. req=0010 in cycle 2 re-sets pending bit 1 with no overflow. req=0010 in cycle 3 -> overflow=1 for exactly cycle 4 (after edge 4), pending stays 0010.
- Reset mid-operation: while PRESENT with out_idx=11 and pending=0110, rst_n=0 for one cycle -> next cycle out_valid=0, pending=0000. After release with req=0, no stale index is ever presented.
